// File: rtl/w_stage_grf_pkg.sv
// Shared constants and types for the write-back stage and register file.
package w_stage_grf_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [DATA_W-1:0] LINK_OFFSET = 32'd8;
  localparam logic [DATA_W-1:0] PC_RESET    = 32'h0000_3000;
  localparam logic [REG_AW-1:0] REG_ZERO    = 5'd0;

  typedef enum logic [1:0] {
    WDSEL_ALU = 2'b00,
    WDSEL_DM  = 2'b01,
    WDSEL_PC  = 2'b10,
    WDSEL_EXT = 2'b11
  } wdsel_e;

  // One committed write as seen by the trace port
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } trace_t;

endpackage

// File: rtl/w_stage_grf_grf_array.sv
// 32-entry register storage: one write port, two raw read ports, async clear.
module w_stage_grf_grf_array
  import w_stage_grf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1_c,
  output logic [DATA_W-1:0] rd2_c
);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];

  // Next array contents: register 0 is never written
  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != REG_ZERO)) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage flops, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Raw reads; register 0 forced to zero
  always_comb begin
    rd1_c = (ra1 == REG_ZERO) ? '0 : mem_q[ra1];
    rd2_c = (ra2 == REG_ZERO) ? '0 : mem_q[ra2];
  end

endmodule

// File: rtl/w_stage_grf.sv
// Write-back stage: WD select, GRF commit with same-cycle read bypass, write trace and counter.
module w_stage_grf
  import w_stage_grf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] W_ALU_O,
  input  logic [DATA_W-1:0] W_DM_O,
  input  logic [DATA_W-1:0] W_PC,
  input  logic [DATA_W-1:0] W_EXT_O,
  input  logic [REG_AW-1:0] W_A3,
  input  logic [1:0]        W_WDSel,
  input  logic [REG_AW-1:0] D_A1,
  input  logic [REG_AW-1:0] D_A2,
  output logic [DATA_W-1:0] D_RD1,
  output logic [DATA_W-1:0] D_RD2,
  output logic [DATA_W-1:0] W_WD,
  output logic              trace_we,
  output logic [DATA_W-1:0] trace_pc,
  output logic [REG_AW-1:0] trace_reg,
  output logic [DATA_W-1:0] trace_data,
  output logic [DATA_W-1:0] write_count
);

  logic [DATA_W-1:0] wd_c;
  logic              commit_c;
  logic [DATA_W-1:0] raw1_c;
  logic [DATA_W-1:0] raw2_c;
  trace_t            trace_q;
  trace_t            trace_d;
  logic [DATA_W-1:0] write_count_q;
  logic [DATA_W-1:0] write_count_d;

  // Write-back value select; link path wraps modulo 2^32
  always_comb begin
    wd_c = W_ALU_O;
    case (wdsel_e'(W_WDSel))
      WDSEL_ALU: wd_c = W_ALU_O;
      WDSEL_DM:  wd_c = W_DM_O;
      WDSEL_PC:  wd_c = W_PC + LINK_OFFSET;
      WDSEL_EXT: wd_c = W_EXT_O;
      default:   wd_c = W_ALU_O;
    endcase
  end

  assign commit_c = (W_A3 != REG_ZERO);
  assign W_WD     = wd_c;

  w_stage_grf_grf_array u_grf (
    .clk   (clk),
    .rst   (reset),
    .we    (commit_c),
    .waddr (W_A3),
    .wdata (wd_c),
    .ra1   (D_A1),
    .ra2   (D_A2),
    .rd1_c (raw1_c),
    .rd2_c (raw2_c)
  );

  // Same-cycle bypass of the W write onto each D read port independently
  always_comb begin
    D_RD1 = (commit_c && (D_A1 == W_A3)) ? wd_c : raw1_c;
    D_RD2 = (commit_c && (D_A2 == W_A3)) ? wd_c : raw2_c;
  end

  // Trace and counter next state; trace fields other than we hold across bubbles
  always_comb begin
    trace_d       = trace_q;
    write_count_d = write_count_q;
    trace_d.we    = commit_c;
    if (commit_c) begin
      trace_d.pc    = W_PC;
      trace_d.rd    = W_A3;
      trace_d.data  = wd_c;
      write_count_d = write_count_q + 32'd1;
    end
  end

  // Trace and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_q       <= '{we: 1'b0, pc: PC_RESET, rd: REG_ZERO, data: '0};
      write_count_q <= '0;
    end else begin
      trace_q       <= trace_d;
      write_count_q <= write_count_d;
    end
  end

  assign trace_we    = trace_q.we;
  assign trace_pc    = trace_q.pc;
  assign trace_reg   = trace_q.rd;
  assign trace_data  = trace_q.data;
  assign write_count = write_count_q;

endmodule

// File: tb/tb_w_stage_grf.sv
// Directed bench for w_stage_grf: combinational paths checked inline, trace checked by a scoreboard.
module tb_w_stage_grf;

  logic        clk;
  logic        reset;
  logic [31:0] W_ALU_O, W_DM_O, W_PC, W_EXT_O;
  logic [4:0]  W_A3;
  logic [1:0]  W_WDSel;
  logic [4:0]  D_A1, D_A2;
  logic [31:0] D_RD1, D_RD2, W_WD;
  logic        trace_we;
  logic [31:0] trace_pc;
  logic [4:0]  trace_reg;
  logic [31:0] trace_data;
  logic [31:0] write_count;

  typedef struct {
    logic        we;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] count;
  } exp_t;

  exp_t        exp_q [$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] count_m = 32'd0;

  w_stage_grf dut (
    .clk         (clk),
    .reset       (reset),
    .W_ALU_O     (W_ALU_O),
    .W_DM_O      (W_DM_O),
    .W_PC        (W_PC),
    .W_EXT_O     (W_EXT_O),
    .W_A3        (W_A3),
    .W_WDSel     (W_WDSel),
    .D_A1        (D_A1),
    .D_A2        (D_A2),
    .D_RD1       (D_RD1),
    .D_RD2       (D_RD2),
    .W_WD        (W_WD),
    .trace_we    (trace_we),
    .trace_pc    (trace_pc),
    .trace_reg   (trace_reg),
    .trace_data  (trace_data),
    .write_count (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one W-stage cycle, check the combinational outputs, queue the trace expectation
  task automatic drive(input logic [4:0] a3, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [31:0] pc, input logic [31:0] ext,
                       input logic [31:0] exp_wd,
                       input logic [4:0] a1, input logic [31:0] exp1,
                       input logic [4:0] a2, input logic [31:0] exp2);
    exp_t e;
    @(negedge clk);
    W_A3 = a3; W_WDSel = sel; W_ALU_O = alu; W_DM_O = dm; W_PC = pc; W_EXT_O = ext;
    D_A1 = a1; D_A2 = a2;
    if (a3 != 5'd0) count_m = count_m + 32'd1;
    e.we = (a3 != 5'd0); e.pc = pc; e.rd = a3; e.data = exp_wd; e.count = count_m;
    exp_q.push_back(e);
    #1;
    chk("w_wd", W_WD, exp_wd);
    chk("d_rd1", D_RD1, exp1);
    chk("d_rd2", D_RD2, exp2);
  endtask

  // Scoreboard monitor: one expectation per driven edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("trace_we", 32'(trace_we), 32'(e.we));
        if (e.we) begin
          chk("trace_pc", trace_pc, e.pc);
          chk("trace_reg", 32'(trace_reg), 32'(e.rd));
          chk("trace_data", trace_data, e.data);
        end
        chk("write_count", write_count, e.count);
      end
    end
  end

  initial begin
    reset = 1'b1;
    W_ALU_O = '0; W_DM_O = '0; W_PC = 32'h3000; W_EXT_O = '0;
    W_A3 = '0; W_WDSel = 2'b00; D_A1 = 5'd8; D_A2 = 5'd31;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd1", D_RD1, 32'h0);
    chk("rst_trace_pc", trace_pc, 32'h3000);
    chk("rst_trace_we", 32'(trace_we), 32'h0);
    chk("rst_count", write_count, 32'h0);
    reset = 1'b0;

    //     a3    sel    alu           dm            pc            ext           wd            a1     rd1           a2     rd2
    drive(5'd8,  2'b00, 32'h1234,     32'h0,        32'h3000,     32'h0,        32'h1234,     5'd8,  32'h1234,     5'd0,  32'h0);
    drive(5'd0,  2'b00, 32'hFFFF,     32'h0,        32'h3004,     32'h0,        32'hFFFF,     5'd8,  32'h1234,     5'd0,  32'h0);
    drive(5'd9,  2'b01, 32'h0,        32'hDEADBEEF, 32'h3008,     32'h0,        32'hDEADBEEF, 5'd8,  32'h1234,     5'd9,  32'hDEADBEEF);
    drive(5'd31, 2'b10, 32'h0,        32'h0,        32'h3010,     32'h0,        32'h3018,     5'd9,  32'hDEADBEEF, 5'd31, 32'h3018);
    drive(5'd30, 2'b10, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h0,        32'h4,        5'd31, 32'h3018,     5'd0,  32'h0);
    drive(5'd5,  2'b11, 32'h0,        32'h0,        32'h3018,     32'hABCD0000, 32'hABCD0000, 5'd5,  32'hABCD0000, 5'd5,  32'hABCD0000);
    drive(5'd8,  2'b00, 32'h55,       32'h0,        32'h301C,     32'h0,        32'h55,       5'd5,  32'hABCD0000, 5'd8,  32'h55);
    drive(5'd0,  2'b01, 32'h0,        32'h77,       32'h3020,     32'h0,        32'h77,       5'd30, 32'h4,        5'd8,  32'h55);

    // Reset mid-cycle while a write is pending: write discarded, state cleared at once
    @(negedge clk);
    W_A3 = 5'd7; W_WDSel = 2'b00; W_ALU_O = 32'h99; D_A1 = 5'd8; D_A2 = 5'd7;
    #2;
    reset = 1'b1;
    W_A3 = 5'd0;
    #1;
    chk("mid_rst_rd1", D_RD1, 32'h0);
    chk("mid_rst_rd2", D_RD2, 32'h0);
    chk("mid_rst_trace_pc", trace_pc, 32'h3000);
    chk("mid_rst_count", write_count, 32'h0);
    count_m = 32'd0;
    @(negedge clk);
    reset = 1'b0;

    drive(5'd0,  2'b00, 32'hFFFF,     32'h0,        32'h3000,     32'h0,        32'hFFFF,     5'd5,  32'h0,        5'd7,  32'h0);

    // Preload counter to all-ones, then one write must wrap it to zero
    @(negedge clk);
    W_A3 = 5'd0;
    force dut.write_count_q = 32'hFFFFFFFF;
    #1;
    release dut.write_count_q;
    count_m = 32'hFFFFFFFF;
    drive(5'd3,  2'b00, 32'h77,       32'h0,        32'h3040,     32'h0,        32'h77,       5'd3,  32'h77,       5'd8,  32'h0);
    drive(5'd0,  2'b00, 32'h0,        32'h0,        32'h3044,     32'h0,        32'h0,        5'd3,  32'h77,       5'd0,  32'h0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
